// File: rtl/nibble_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_tx
// Description : Parallel-to-serial transmitter. Accepts W-bit words over a
//               valid/ready handshake and shifts them out LSB-first on X, one
//               bit per CLK. A one-entry hold register sits behind the shift
//               register so consecutive words leave with no idle gap. FRAME
//               marks bit 0 of every word, BUSY marks every data bit.
//
// Parameters  : W          - word width in bits (>= 2)
//               IDLE_LEVEL - level driven on X while no word is shifting
//
// Ports       : CLK       in   rising-edge clock
//               CLR       in   asynchronous active-high reset
//               DIN       in   parallel word (W bits)
//               DIN_VALID in   DIN is valid this cycle
//               DIN_READY out  block can accept a word (= !hold_full)
//               X         out  serial data, registered
//               FRAME     out  high while X carries bit 0 of a word
//               BUSY      out  high while X carries any data bit
//
// Option      : NIBBLE_SERIAL_TX_EXCESS3_EN - when defined, each accepted
//               word is encoded as DIN + 3 (mod 2^W) before it is stored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_tx #(
    parameter int   W          = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VALID,
    output logic         DIN_READY,
    output logic         X,
    output logic         FRAME,
    output logic         BUSY
);

    localparam int              C_CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(W - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_shift;
    logic [W-1:0]      r_hold;
    logic              r_hold_full;
    logic [C_CW-1:0]   r_cnt;

    state_t            w_state_nxt;
    logic [W-1:0]      w_shift_nxt;
    logic [W-1:0]      w_hold_nxt;
    logic              w_hold_full_nxt;
    logic [C_CW-1:0]   w_cnt_nxt;
    logic              w_accept;
    logic [W-1:0]      w_word;

    // Ready depends on registered state only, never on DIN_VALID.
    assign DIN_READY = !r_hold_full;
    assign w_accept  = DIN_VALID && !r_hold_full;

    // Encoding is applied once at acceptance so shifter and hold agree.
`ifdef NIBBLE_SERIAL_TX_EXCESS3_EN
    assign w_word = DIN + W'(3);
`else
    assign w_word = DIN;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = w_word;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != C_LAST) begin
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (w_accept) begin
                        w_hold_nxt      = w_word;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    // Hold has priority; DIN_READY is low so no transfer here.
                    w_shift_nxt     = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_accept) begin
                    w_shift_nxt = w_word;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so bit 0 of a word is on
    // X in the cycle directly after the accepting edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            X           <= IDLE_LEVEL;
            FRAME       <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
            X           <= (w_state_nxt == S_SHIFT) ? w_shift_nxt[0] : IDLE_LEVEL;
            FRAME       <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0);
            BUSY        <= (w_state_nxt == S_SHIFT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_tx
// Description : Directed self-checking bench for nibble_serial_tx (W=4,
//               IDLE_LEVEL=0). Single word, back-to-back words through the
//               hold register, three-word stream, asynchronous reset
//               mid-word, and the excess-3 option (expectations follow the
//               NIBBLE_SERIAL_TX_EXCESS3_EN macro).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_tx;

    logic       CLK;
    logic       CLR;
    logic [3:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic       X;
    logic       FRAME;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    nibble_serial_tx #(
        .W          (4),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .X         (X),
        .FRAME     (FRAME),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x"},     X,         1'b0);
        chk({tag, "_frame"}, FRAME,     1'b0);
        chk({tag, "_busy"},  BUSY,      1'b0);
        chk({tag, "_ready"}, DIN_READY, 1'b1);
    endtask

    // Send one word from idle and check the four serial bits, then idle.
    task automatic send_word(input string tag, input logic [3:0] d, input logic [3:0] e);
        DIN       = d;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_x%0d", tag, i),     X,     e[i]);
            chk($sformatf("%s_frame%0d", tag, i), FRAME, (i == 0));
            chk($sformatf("%s_busy%0d", tag, i),  BUSY,  1'b1);
            tick();
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        logic [7:0]  s2;
        logic [11:0] s3;
        logic [3:0]  e5a;
        logic [3:0]  e5b;

        CLR       = 1'b1;
        DIN       = 4'h0;
        DIN_VALID = 1'b0;

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        CLR = 1'b0;

        // 1: single word 4'b1011 -> 1,1,0,1
        send_word("t1", 4'hB, 4'hB);
        tick();
        chk_idle("t1_later");

        // 2: 4'hA then 4'h5 back to back
        s2        = 8'h5A;
        DIN       = 4'hA;
        DIN_VALID = 1'b1;
        tick();
        DIN = 4'h5;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_x%0d", i),     X,     s2[i]);
            chk($sformatf("t2_frame%0d", i), FRAME, (i == 0) || (i == 4));
            chk($sformatf("t2_busy%0d", i),  BUSY,  1'b1);
            chk($sformatf("t2_ready%0d", i), DIN_READY, !((i >= 1) && (i <= 3)));
            tick();
            if (i == 0) DIN_VALID = 1'b0;
        end
        chk_idle("t2_end");

        // 3: three words with valid held high
        s3        = 12'h321;
        DIN       = 4'h1;
        DIN_VALID = 1'b1;
        tick();
        DIN = 4'h2;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_x%0d", i),     X,     s3[i]);
            chk($sformatf("t3_frame%0d", i), FRAME, (i % 4) == 0);
            chk($sformatf("t3_busy%0d", i),  BUSY,  1'b1);
            chk($sformatf("t3_ready%0d", i), DIN_READY, (i == 0) || (i == 4) || (i >= 8));
            tick();
            if (i == 0) DIN = 4'h3;
            if (i == 4) DIN_VALID = 1'b0;
        end
        chk_idle("t3_end");

        // 4: asynchronous reset during bit 2 of 4'hF with 4'h6 held
        DIN       = 4'hF;
        DIN_VALID = 1'b1;
        tick();
        DIN = 4'h6;
        tick();
        DIN_VALID = 1'b0;
        chk("t4_hold_ready", DIN_READY, 1'b0);
        tick();
        chk("t4_bit2_busy", BUSY, 1'b1);
        chk("t4_bit2_x",    X,    1'b1);
        #2;
        CLR = 1'b1;
        #1;
        chk_idle("t4_async");
        #1;
        CLR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_after_x%0d", i),    X,    1'b0);
            chk($sformatf("t4_after_busy%0d", i), BUSY, 1'b0);
        end

        // 5: excess-3 option (or plain pass-through when not enabled)
`ifdef NIBBLE_SERIAL_TX_EXCESS3_EN
        e5a = 4'h0;
        e5b = 4'h5;
`else
        e5a = 4'hD;
        e5b = 4'h2;
`endif
        send_word("t5_d", 4'hD, e5a);
        send_word("t5_2", 4'h2, e5b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
